alu_dec_stage: RTL

- Registered ID/EX decode stage that drives the ALU control interface (AluCtrl, shamt, operand-B select/immediate) from a raw MIPS instruction word.
- Sits between the instruction decoder and the ALU. Produces the 4-bit AluCtrl encoding the ALU consumes, one cycle after the instruction is presented.
- Supports pipeline stall (hold) and flush (bubble insertion).

---
 rtl/alu_dec_stage.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_dec_stage.sv
// ID/EX decode stage: turns a raw MIPS instruction word into registered ALU
// control (operation, shift amount, operand-B select, extended immediate).
module alu_dec_stage (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_con_Valid,
    input  logic [31:0] i_data_Instr,
    input  logic        i_con_Stall,
    input  logic        i_con_Flush,
    output logic        o_con_Valid,
    output logic [3:0]  o_con_AluCtrl,
    output logic [4:0]  o_data_shamt,
    output logic        o_con_AluSrcImm,
    output logic [31:0] o_data_Imm,
    output logic        o_con_Branch,
    output logic        o_con_Jr,
    output logic        o_con_Illegal
);

    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SLL = 4'd3,
        ALU_SRL = 4'd4,
        ALU_EQ  = 4'd5,
        ALU_SUB = 4'd6,
        ALU_SLT = 4'd7,
        ALU_NOR = 4'd12,
        ALU_XOR = 4'd13
    } alu_ctrl_e;

    typedef struct packed {
        logic        valid;
        alu_ctrl_e   alu_ctrl;
        logic [4:0]  shamt;
        logic        alu_src_imm;
        logic [31:0] imm;
        logic        branch;
        logic        jr;
        logic        illegal;
    } stage_t;

    localparam stage_t BUBBLE = '{
        valid:       1'b0,
        alu_ctrl:    ALU_AND,
        shamt:       5'd0,
        alu_src_imm: 1'b0,
        imm:         32'd0,
        branch:      1'b0,
        jr:          1'b0,
        illegal:     1'b0
    };

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  instr_shamt;
    logic [31:0] imm_se;
    logic [31:0] imm_ze;
    logic        unused_reg_fields;

    assign op          = i_data_Instr[31:26];
    assign funct       = i_data_Instr[5:0];
    assign instr_shamt = i_data_Instr[10:6];
    assign imm_se      = {{16{i_data_Instr[15]}}, i_data_Instr[15:0]};
    assign imm_ze      = {16'd0, i_data_Instr[15:0]};
    // rs/rt are consumed by the register file, not by this stage
    assign unused_reg_fields = ^i_data_Instr[25:16];

    stage_t dec;
    stage_t stage_d;
    stage_t stage_q;

    always_comb begin
        dec       = BUBBLE;
        dec.valid = 1'b1;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU: dec.alu_ctrl = ALU_ADD;
                    FN_SUB, FN_SUBU: dec.alu_ctrl = ALU_SUB;
                    FN_AND:          dec.alu_ctrl = ALU_AND;
                    FN_OR:           dec.alu_ctrl = ALU_OR;
                    FN_XOR:          dec.alu_ctrl = ALU_XOR;
                    FN_NOR:          dec.alu_ctrl = ALU_NOR;
                    FN_SLT, FN_SLTU: dec.alu_ctrl = ALU_SLT;
                    FN_SLL: begin
                        dec.alu_ctrl = ALU_SLL;
                        dec.shamt    = instr_shamt;
                    end
                    FN_SRL: begin
                        dec.alu_ctrl = ALU_SRL;
                        dec.shamt    = instr_shamt;
                    end
                    FN_JR: begin
                        dec.alu_ctrl = ALU_ADD;
                        dec.jr       = 1'b1;
                    end
                    default:         dec.illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
                dec.alu_ctrl    = ALU_ADD;
                dec.alu_src_imm = 1'b1;
                dec.imm         = imm_se;
            end
            OP_SLTI, OP_SLTIU: begin
                dec.alu_ctrl    = ALU_SLT;
                dec.alu_src_imm = 1'b1;
                dec.imm         = imm_se;
            end
            OP_ANDI: begin
                dec.alu_ctrl    = ALU_AND;
                dec.alu_src_imm = 1'b1;
                dec.imm         = imm_ze;
            end
            OP_ORI: begin
                dec.alu_ctrl    = ALU_OR;
                dec.alu_src_imm = 1'b1;
                dec.imm         = imm_ze;
            end
            OP_XORI: begin
                dec.alu_ctrl    = ALU_XOR;
                dec.alu_src_imm = 1'b1;
                dec.imm         = imm_ze;
            end
            // lui is executed as a shift-left-by-16 of the zero-extended immediate
            OP_LUI: begin
                dec.alu_ctrl    = ALU_SLL;
                dec.alu_src_imm = 1'b1;
                dec.imm         = imm_ze;
                dec.shamt       = 5'd16;
            end
            OP_BEQ: begin
                dec.alu_ctrl = ALU_SUB;
                dec.branch   = 1'b1;
                dec.imm      = imm_se;
            end
            // EQ yields 1 on equality, so Zero=1 means "not equal": taken on Zero
            OP_BNE: begin
                dec.alu_ctrl = ALU_EQ;
                dec.branch   = 1'b1;
                dec.imm      = imm_se;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    always_comb begin
        stage_d = BUBBLE;
        if (i_con_Valid) begin
            stage_d = dec;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stage_q <= BUBBLE;
        end else if (i_con_Flush) begin
            stage_q <= BUBBLE;
        end else if (!i_con_Stall) begin
            stage_q <= stage_d;
        end
    end

    assign o_con_Valid     = stage_q.valid;
    assign o_con_AluCtrl   = stage_q.alu_ctrl;
    assign o_data_shamt    = stage_q.shamt;
    assign o_con_AluSrcImm = stage_q.alu_src_imm;
    assign o_data_Imm      = stage_q.imm;
    assign o_con_Branch    = stage_q.branch;
    assign o_con_Jr        = stage_q.jr;
    assign o_con_Illegal   = stage_q.illegal;

endmodule
